// File: rtl/rmii_rx_sequencer.sv
// RMII receive front end: hunts preamble/SFD, forwards payload dibits with one
// cycle of latency, and reports per-frame length and error status.
module rmii_rx_sequencer #(
  parameter int PRE_MIN    = 12,
  parameter int MIN_DIBITS = 256,
  parameter int MAX_DIBITS = 6072,
  parameter int CW         = $clog2(MAX_DIBITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          crsdv,
  input  logic [1:0]    rxd,
  output logic          axiov,
  output logic [1:0]    axiod,
  output logic          frame_start,
  output logic          frame_done,
  output logic          frame_err,
  output logic [CW-2:0] frame_len,
  output logic [1:0]    dbg_state
);

  // Handshake: axiov/axiod is a valid-only stream with no back-pressure; each
  // cycle axiov=1 carries exactly one payload dibit, in wire order.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t          state_q;
  logic [4:0]      pre_cnt_q;
  logic [CW-1:0]   dcnt_q;
  logic            axiov_q;
  logic [1:0]      axiod_q;
  logic            frame_start_q;
  logic            frame_done_q;
  logic            frame_err_q;
  logic [CW-2:0]   frame_len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pre_cnt_q     <= '0;
      dcnt_q        <= '0;
      axiov_q       <= 1'b0;
      axiod_q       <= 2'b00;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_len_q   <= '0;
    end else begin
      axiov_q       <= 1'b0;
      axiod_q       <= 2'b00;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (crsdv && rxd == 2'b01) begin
            state_q   <= PREAMBLE;
            pre_cnt_q <= 5'd1;
          end
        end

        PREAMBLE: begin
          if (!crsdv) begin
            state_q <= IDLE;
          end else begin
            case (rxd)
              2'b01: begin
                if (pre_cnt_q != 5'd31) pre_cnt_q <= pre_cnt_q + 5'd1;
              end
              2'b11: begin
                if (pre_cnt_q >= 5'(PRE_MIN)) begin
                  state_q       <= DATA;
                  dcnt_q        <= '0;
                  frame_start_q <= 1'b1;
                end else begin
                  state_q <= DROP;
                end
              end
              default: state_q <= DROP;
            endcase
          end
        end

        DATA: begin
          if (crsdv) begin
            if (dcnt_q < CW'(MAX_DIBITS)) begin
              axiov_q <= 1'b1;
              axiod_q <= rxd;
              dcnt_q  <= dcnt_q + 1'b1;
            end else begin
              // Overlong: close the frame now and discard the rest of the carrier.
              frame_done_q <= 1'b1;
              frame_err_q  <= 1'b1;
              frame_len_q  <= (CW-1)'(MAX_DIBITS / 4);
              state_q      <= DROP;
            end
          end else begin
            frame_done_q <= 1'b1;
            frame_err_q  <= (dcnt_q < CW'(MIN_DIBITS)) || (dcnt_q[1:0] != 2'b00);
            frame_len_q  <= {1'b0, dcnt_q[CW-1:2]};
            state_q      <= IDLE;
          end
        end

        DROP: begin
          if (!crsdv) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign axiov       = axiov_q;
  assign axiod       = axiod_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign frame_len   = frame_len_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rmii_rx_sequencer.sv
// Directed bench for rmii_rx_sequencer: drives RMII frames and checks the
// payload stream, frame pulses, lengths and error flags.
module tb_rmii_rx_sequencer;
  localparam int PRE_MIN    = 12;
  localparam int MIN_DIBITS = 256;
  localparam int MAX_DIBITS = 6072;
  localparam int CW         = $clog2(MAX_DIBITS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          crsdv = 1'b0;
  logic [1:0]    rxd = 2'b00;
  logic          axiov;
  logic [1:0]    axiod;
  logic          frame_start;
  logic          frame_done;
  logic          frame_err;
  logic [CW-2:0] frame_len;
  logic [1:0]    dbg_state;

  rmii_rx_sequencer #(
    .PRE_MIN(PRE_MIN), .MIN_DIBITS(MIN_DIBITS), .MAX_DIBITS(MAX_DIBITS), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .axiov(axiov), .axiod(axiod), .frame_start(frame_start),
    .frame_done(frame_done), .frame_err(frame_err), .frame_len(frame_len),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  // scoreboard state
  logic [1:0] exp_q[$];
  logic [1:0] exp_d;
  int axiov_cnt = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int start_cyc = -1, done_cyc = -1, last_axiov_cyc = -1, last_len = -1;
  int last_err = -1;
  int sfd_cyc = 0, end_cyc = 0, ovl_cyc = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (axiov === 1'b1) begin
        axiov_cnt++;
        last_axiov_cyc = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL axiod_extra: got dibit %0d, required no output (cyc %0d)", axiod, cyc);
        end else begin
          exp_d = exp_q.pop_front();
          if (axiod !== exp_d) begin
            failed++;
            $display("FAIL axiod: got %0d, required %0d (cyc %0d)", axiod, exp_d, cyc);
          end
        end
      end
      if (frame_start === 1'b1) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        last_err = int'(frame_err);
        last_len = int'(frame_len);
        if (frame_err === 1'b1) err_cnt++;
      end else if (frame_err !== 1'b0) begin
        tests++;
        failed++;
        $display("FAIL err_without_done: got frame_err=%b, required 0 (cyc %0d)", frame_err, cyc);
      end
    end
  end

  // drivers
  task automatic drive(input logic c, input logic [1:0] d);
    @(posedge clk);
    #1;
    crsdv = c;
    rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 2'b00);
  endtask

  task automatic send_frame(input int npre, input int npay, input bit push);
    logic [1:0] d;
    for (int k = 0; k < npre; k++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    sfd_cyc = cyc;
    for (int k = 0; k < npay; k++) begin
      d = 2'(k);
      drive(1'b1, d);
      if (k == MAX_DIBITS) ovl_cyc = cyc;
      if (push && k < MAX_DIBITS) exp_q.push_back(d);
    end
    drive(1'b0, 2'b00);
    end_cyc = cyc;
  endtask

  // scenarios
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (axiov !== 1'b0) begin failed++; $display("FAIL reset_axiov: got %b, required 0", axiov); end
    tests++; if (frame_start !== 1'b0) begin failed++; $display("FAIL reset_start: got %b, required 0", frame_start); end
    tests++; if (frame_done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b, required 0", frame_done); end
    tests++; if (frame_err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b, required 0", frame_err); end
    tests++; if (frame_len !== '0) begin failed++; $display("FAIL reset_len: got %0d, required 0", frame_len); end
    tests++; if (dbg_state !== 2'd0) begin failed++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame(input string nm, input int npre);
    int a0, s0, d0, e0;
    a0 = axiov_cnt; s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
    send_frame(npre, 256, 1'b1);
    idle(3);
    tests++; if (start_cnt - s0 !== 1) begin failed++; $display("FAIL %s_start_cnt: got %0d, required 1", nm, start_cnt - s0); end
    tests++; if (start_cyc !== sfd_cyc + 1) begin failed++; $display("FAIL %s_start_cyc: got %0d, required %0d", nm, start_cyc, sfd_cyc + 1); end
    tests++; if (axiov_cnt - a0 !== 256) begin failed++; $display("FAIL %s_axiov_cnt: got %0d, required 256", nm, axiov_cnt - a0); end
    tests++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL %s_done_cnt: got %0d, required 1", nm, done_cnt - d0); end
    tests++; if (done_cyc !== end_cyc + 1) begin failed++; $display("FAIL %s_done_cyc: got %0d, required %0d", nm, done_cyc, end_cyc + 1); end
    tests++; if (last_axiov_cyc !== done_cyc - 1) begin failed++; $display("FAIL %s_axiov_end: got %0d, required %0d", nm, last_axiov_cyc, done_cyc - 1); end
    tests++; if (err_cnt - e0 !== 0 || last_err !== 0) begin failed++; $display("FAIL %s_err: got %0d, required 0", nm, last_err); end
    tests++; if (last_len !== 64) begin failed++; $display("FAIL %s_len: got %0d, required 64", nm, last_len); end
    tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL %s_pending: got %0d, required 0", nm, exp_q.size()); end
  endtask

  task automatic test_short_preamble;
    int a0, s0, d0;
    a0 = axiov_cnt; s0 = start_cnt; d0 = done_cnt;
    send_frame(5, 50, 1'b0);
    idle(2);
    send_frame(PRE_MIN - 1, 50, 1'b0);
    idle(2);
    tests++; if (axiov_cnt - a0 !== 0) begin failed++; $display("FAIL short_pre_axiov: got %0d, required 0", axiov_cnt - a0); end
    tests++; if (start_cnt - s0 !== 0) begin failed++; $display("FAIL short_pre_start: got %0d, required 0", start_cnt - s0); end
    tests++; if (done_cnt - d0 !== 0) begin failed++; $display("FAIL short_pre_done: got %0d, required 0", done_cnt - d0); end
  endtask

  task automatic test_bad_len(input string nm, input int npay, input int exp_len);
    int a0, d0;
    a0 = axiov_cnt; d0 = done_cnt;
    send_frame(15, npay, 1'b1);
    idle(3);
    tests++; if (axiov_cnt - a0 !== npay) begin failed++; $display("FAIL %s_axiov_cnt: got %0d, required %0d", nm, axiov_cnt - a0, npay); end
    tests++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL %s_done_cnt: got %0d, required 1", nm, done_cnt - d0); end
    tests++; if (last_err !== 1) begin failed++; $display("FAIL %s_err: got %0d, required 1", nm, last_err); end
    tests++; if (last_len !== exp_len) begin failed++; $display("FAIL %s_len: got %0d, required %0d", nm, last_len, exp_len); end
  endtask

  task automatic test_overlong;
    int a0, d0;
    a0 = axiov_cnt; d0 = done_cnt;
    send_frame(15, 6100, 1'b1);
    idle(3);
    tests++; if (axiov_cnt - a0 !== MAX_DIBITS) begin failed++; $display("FAIL ovl_axiov_cnt: got %0d, required %0d", axiov_cnt - a0, MAX_DIBITS); end
    tests++; if (last_axiov_cyc !== ovl_cyc) begin failed++; $display("FAIL ovl_axiov_end: got %0d, required %0d", last_axiov_cyc, ovl_cyc); end
    tests++; if (done_cnt - d0 !== 1) begin failed++; $display("FAIL ovl_done_cnt: got %0d, required 1", done_cnt - d0); end
    tests++; if (done_cyc !== ovl_cyc + 1) begin failed++; $display("FAIL ovl_done_cyc: got %0d, required %0d", done_cyc, ovl_cyc + 1); end
    tests++; if (last_err !== 1) begin failed++; $display("FAIL ovl_err: got %0d, required 1", last_err); end
    tests++; if (last_len !== 1518) begin failed++; $display("FAIL ovl_len: got %0d, required 1518", last_len); end
    tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL ovl_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset;
    int a0, d0;
    logic [1:0] d;
    a0 = axiov_cnt; d0 = done_cnt;
    for (int k = 0; k < 15; k++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int k = 0; k < 100; k++) begin
      d = 2'(k);
      drive(1'b1, d);
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1 rst = 1'b1; rxd = 2'b10;
    @(posedge clk);
    @(negedge clk);
    tests++; if (axiov !== 1'b0) begin failed++; $display("FAIL midrst_axiov: got %b, required 0", axiov); end
    tests++; if (dbg_state !== 2'd0) begin failed++; $display("FAIL midrst_state: got %0d, required 0", dbg_state); end
    @(posedge clk);
    #1 rst = 1'b0; crsdv = 1'b0; rxd = 2'b00;
    idle(3);
    tests++; if (done_cnt - d0 !== 0) begin failed++; $display("FAIL midrst_done: got %0d, required 0", done_cnt - d0); end
    tests++; if (axiov_cnt - a0 !== 100) begin failed++; $display("FAIL midrst_axiov_cnt: got %0d, required 100", axiov_cnt - a0); end
    test_good_frame("after_rst", 15);
  endtask

  task automatic test_back_to_back;
    int a0, s0, d0, e0;
    a0 = axiov_cnt; s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
    send_frame(15, 256, 1'b1);
    send_frame(15, 256, 1'b1);
    idle(3);
    tests++; if (start_cnt - s0 !== 2) begin failed++; $display("FAIL b2b_start: got %0d, required 2", start_cnt - s0); end
    tests++; if (done_cnt - d0 !== 2) begin failed++; $display("FAIL b2b_done: got %0d, required 2", done_cnt - d0); end
    tests++; if (err_cnt - e0 !== 0) begin failed++; $display("FAIL b2b_err: got %0d, required 0", err_cnt - e0); end
    tests++; if (axiov_cnt - a0 !== 512) begin failed++; $display("FAIL b2b_axiov_cnt: got %0d, required 512", axiov_cnt - a0); end
    tests++; if (last_len !== 64) begin failed++; $display("FAIL b2b_len: got %0d, required 64", last_len); end
    tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_good_frame("good", 15);
    test_good_frame("pre_min", PRE_MIN);
    test_short_preamble();
    test_bad_len("runt", 40, 10);
    test_bad_len("dribble", 258, 64);
    test_overlong();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rmii_rx_sequencer.md
Name: rmii_rx_sequencer

Overview:
- Front-end controller for the RMII receive path.
- Watches CRS_DV and the 2-bit RXD stream, and hunts for the preamble and SFD.
- Forwards only payload dibits (destination MAC through FCS) on an AXI-stream-style valid/data pair to the downstream dibit-to-word aggregator.
- Enforces min/max frame length and reports per-frame completion, length and error status to the packet-handling logic.

Parameters:
- PRE_MIN, 12: minimum count of consecutive 01 preamble dibits required before the SFD dibit 11 is accepted.
- MIN_DIBITS, 256: minimum legal payload length in dibits (64 bytes).
- MAX_DIBITS, 6072: maximum legal payload length in dibits (1518 bytes).
- CW, $clog2(MAX_DIBITS+1): width of the payload dibit counter.

Ports:
- clk  in  1  50 MHz RMII reference clock.
- rst  in  1  synchronous, active-high reset.
- crsdv  in  1  RMII carrier sense / data valid.
- rxd  in  2  RMII receive dibit.
- axiov  out  1  payload dibit valid to aggregator.
- axiod  out  2  payload dibit to aggregator.
- frame_start  out  1  one-cycle pulse; SFD accepted.
- frame_done  out  1  one-cycle pulse; frame that entered DATA has ended.
- frame_err  out  1  qualifies frame_done; frame bad.
- frame_len  out  CW-1  payload byte count, valid when frame_done=1.

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- All outputs are registered. Reset forces state IDLE and clears every output and counter to 0.
- Reset mid-frame: outputs are 0 on the next cycle; no frame_done pulse is generated.
- States: IDLE, PREAMBLE, DATA, DROP. pre_cnt is 5-bit and saturates at 31; dcnt is CW bits.
- IDLE:
  - crsdv=1 and rxd=01 -> PREAMBLE, pre_cnt=1.
  - Otherwise stay in IDLE.
- PREAMBLE:
  - crsdv=0 -> IDLE.
  - rxd=01 -> pre_cnt+1.
  - rxd=11 and pre_cnt>=PRE_MIN -> DATA, dcnt=0; frame_start=1 the following cycle.
  - rxd=11 and pre_cnt<PRE_MIN -> DROP.
  - rxd=00 or 10 -> DROP.
- DATA, crsdv=1:
  - If dcnt<MAX_DIBITS: axiov=1 and axiod=rxd on the next cycle (1-cycle latency, order preserved, SFD never forwarded); dcnt+1.
  - If dcnt==MAX_DIBITS: overlong. Next cycle frame_done=1, frame_err=1, frame_len=MAX_DIBITS>>2, axiov=0; go to DROP.
- DATA, crsdv=0 (end of frame):
  - Next cycle: frame_done=1, axiov=0, frame_len=dcnt>>2.
  - frame_err=1 if dcnt<MIN_DIBITS or dcnt[1:0]!=0 (dribble / partial byte).
  - Go to IDLE.
- DROP: axiov=0 and no pulses; stay until crsdv=0, then IDLE.
- axiov deasserts exactly one cycle after the last payload dibit. No gaps within a frame: crsdv toggling is not treated as mid-byte carrier restoration in this revision.
- frame_start, frame_done and frame_err are single-cycle pulses, 0 otherwise. frame_len holds its value until the next frame_done.
- Back-to-back frames: one crsdv=0 cycle between frames suffices. The done pulse of frame N and a new PREAMBLE entry may coincide.

Test Plan:
- Good 64-byte frame:
  - Stimulus: 15x01, 11, then 256 payload dibits (incrementing pattern), then crsdv=0.
  - Required: frame_start one cycle after SFD; axiov high for exactly 256 cycles; axiod matches input delayed 1 cycle; frame_done=1, frame_err=0, frame_len=64.
- Short preamble:
  - Stimulus: 5x01 then 11, then data.
  - Required: DROP; axiov never asserts; no frame_start or frame_done.
- Runt frame:
  - Stimulus: valid preamble/SFD, then 40 dibits, then crsdv=0.
  - Required: 40 axiov cycles; frame_done=1, frame_err=1, frame_len=10.
- Overlong frame:
  - Stimulus: valid preamble/SFD, then 6100 dibits.
  - Required: axiov for exactly 6072 cycles; frame_done+frame_err on the next cycle, frame_len=1518; no further output until crsdv falls and a new frame starts.
- Dribble frame:
  - Stimulus: 258 payload dibits.
  - Required: frame_err=1, frame_len=64.
- Mid-frame reset:
  - Stimulus: rst pulsed at payload dibit 100.
  - Required: axiov=0 the next cycle, no frame_done; a following good frame is received normally.
- Back-to-back:
  - Stimulus: two good 64-byte frames separated by 1 crsdv=0 cycle.
  - Required: two frame_start/frame_done pairs, both frame_err=0.
